// File: rtl/sv_uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package sv_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_XFER = 2'd2
  } arb_state_t;

  // Port-id width; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sv_uart_tx_arb_if.sv
// Stream bundle between the requesters, the arbiter and the UART transmitter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface sv_uart_tx_arb_if #(
  parameter int N_PORTS    = 4,
  parameter int DATA_WIDTH = 8
);
  import sv_uart_pkg::*;

  localparam int ID_WIDTH = id_width(N_PORTS);

  logic [N_PORTS-1:0][DATA_WIDTH-1:0] s_axis_tdata;
  logic [N_PORTS-1:0]                 s_axis_tvalid;
  logic [N_PORTS-1:0]                 s_axis_tlast;
  logic [N_PORTS-1:0]                 s_axis_tready;
  logic [DATA_WIDTH-1:0]              m_axis_tdata;
  logic                               m_axis_tvalid;
  logic                               m_axis_tready;
  logic [ID_WIDTH-1:0]                m_axis_tid;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tid
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tid
  );

endinterface

// File: rtl/sv_uart_rr_pick.sv
// Rotating-priority picker: first set req bit at or after ptr, wrapping.
module sv_uart_rr_pick
  import sv_uart_pkg::*;
#(
  parameter int N_PORTS  = 4,
  parameter int ID_WIDTH = id_width(N_PORTS)
) (
  input  logic [N_PORTS-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [N_PORTS-1:0]  gnt,
  output logic [ID_WIDTH-1:0] id
);

  logic [ID_WIDTH:0]   sum;
  logic [ID_WIDTH-1:0] idx;
  logic                found;

  // Walk the ports starting at ptr; the first hit wins.
  always_comb begin
    gnt   = '0;
    id    = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      sum = {1'b0, ptr} + (ID_WIDTH+1)'(i);
      if (sum >= (ID_WIDTH+1)'(N_PORTS)) sum = sum - (ID_WIDTH+1)'(N_PORTS);
      idx = sum[ID_WIDTH-1:0];
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        id       = idx;
      end
    end
  end

endmodule

// File: rtl/sv_uart_tx_arb.sv
// Round-robin arbiter funnelling N stream requesters into one UART
// transmitter. A grant is held for a whole message (until tlast) so
// characters of different messages never interleave.
module sv_uart_tx_arb
  import sv_uart_pkg::*;
#(
  parameter int N_PORTS    = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic               iclk,
  input  logic               irst,
  sv_uart_tx_arb_if.slave    bus,
  input  logic [N_PORTS-1:0] iport_ena,
  output logic [N_PORTS-1:0] ogrant,
  output logic               obusy
);

  localparam int ID_WIDTH = id_width(N_PORTS);
  localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(N_PORTS - 1);

  arb_state_t            state;
  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [ID_WIDTH-1:0]   gid_q;
  logic [N_PORTS-1:0]    gnt_q;
  logic [ID_WIDTH-1:0]   pick_id;
  logic [N_PORTS-1:0]    pick_gnt;
  logic [N_PORTS-1:0]    req;
  logic                  m_vld_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic [ID_WIDTH-1:0]   m_tid_q;
  logic                  out_free;
  logic                  accept;
  logic                  beat_last;
  logic [DATA_WIDTH-1:0] beat_data;

  assign req = bus.s_axis_tvalid & iport_ena;

  sv_uart_rr_pick #(
    .N_PORTS  (N_PORTS),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req (req),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .id  (pick_id)
  );

  // Output register can take a beat when empty or draining this cycle;
  // ready depends only on registered state and m_axis_tready.
  assign out_free          = !m_vld_q || bus.m_axis_tready;
  assign bus.s_axis_tready = (state == ST_XFER && out_free) ? gnt_q : '0;
  assign accept            = |(bus.s_axis_tvalid & bus.s_axis_tready);
  assign beat_data         = bus.s_axis_tdata[gid_q];
  assign beat_last         = bus.s_axis_tlast[gid_q];

  // Arbitration FSM: idle -> pick one port -> hold it until its tlast beat.
  always_ff @(posedge iclk) begin
    if (irst) begin
      state  <= ST_IDLE;
      rr_ptr <= '0;
      gnt_q  <= '0;
      gid_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (|req) state <= ST_ARB;
        ST_ARB: begin
          // Request may have vanished since idle; fall back with no grant.
          if (|pick_gnt) begin
            gnt_q <= pick_gnt;
            gid_q <= pick_id;
            state <= ST_XFER;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_XFER: begin
          // Enable/valid drops mid-message are ignored; only tlast releases.
          if (accept && beat_last) begin
            gnt_q  <= '0;
            rr_ptr <= (gid_q == LAST_ID) ? '0 : gid_q + 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Single output stage: load on accept, otherwise drop valid on hand-off.
  always_ff @(posedge iclk) begin
    if (irst) begin
      m_vld_q  <= 1'b0;
      m_data_q <= '0;
      m_tid_q  <= '0;
    end else if (accept) begin
      m_vld_q  <= 1'b1;
      m_data_q <= beat_data;
      m_tid_q  <= gid_q;
    end else if (bus.m_axis_tready) begin
      m_vld_q  <= 1'b0;
    end
  end

  assign bus.m_axis_tvalid = m_vld_q;
  assign bus.m_axis_tdata  = m_data_q;
  assign bus.m_axis_tid    = m_tid_q;
  assign ogrant            = gnt_q;
  assign obusy             = (state == ST_XFER) || m_vld_q;

endmodule

// File: tb/tb_sv_uart_tx_arb.sv
// Self-checking bench for sv_uart_tx_arb: per-port source queues feed the
// DUT, expected output beats are queued in scoreboard order.
module tb_sv_uart_tx_arb;
  import sv_uart_pkg::*;

  localparam int N   = 4;
  localparam int DW  = 8;

  typedef struct packed { logic [7:0] data; logic last; } beat_t;
  typedef struct packed { logic [7:0] data; logic [1:0] tid; } exp_t;

  logic         iclk = 1'b0;
  logic         irst = 1'b1;
  logic [N-1:0] iport_ena;
  logic [N-1:0] ogrant;
  logic         obusy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  beat_t        src_q [N][$];
  exp_t         exp_q [$];
  logic [N-1:0] grant_log [$];
  int           fire_cyc [$];
  logic [N-1:0] prev_gnt = '0;
  logic [N-1:0] fire;

  always #5 iclk = ~iclk;
  always @(posedge iclk) cyc <= cyc + 1;

  sv_uart_tx_arb_if #(.N_PORTS(N), .DATA_WIDTH(DW)) bus ();

  sv_uart_tx_arb #(.N_PORTS(N), .DATA_WIDTH(DW)) dut (
    .iclk      (iclk),
    .irst      (irst),
    .bus       (bus),
    .iport_ena (iport_ena),
    .ogrant    (ogrant),
    .obusy     (obusy)
  );

  // Source driver: retire a beat after its handshake, present the next one.
  initial begin
    bus.s_axis_tvalid = '0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tlast  = '0;
    forever begin
      @(negedge iclk);
      fire = (irst === 1'b1) ? '0 : (bus.s_axis_tvalid & bus.s_axis_tready);
      @(posedge iclk);
      #2;
      for (int p = 0; p < N; p++) begin
        if (fire[p] === 1'b1 && src_q[p].size() > 0) void'(src_q[p].pop_front());
        if (src_q[p].size() > 0) begin
          bus.s_axis_tvalid[p] = 1'b1;
          bus.s_axis_tdata[p]  = src_q[p][0].data;
          bus.s_axis_tlast[p]  = src_q[p][0].last;
        end else begin
          bus.s_axis_tvalid[p] = 1'b0;
          bus.s_axis_tdata[p]  = '0;
          bus.s_axis_tlast[p]  = 1'b0;
        end
      end
    end
  end

  // Scoreboard / grant monitor, sampled mid-cycle.
  always @(negedge iclk) begin
    if (bus.m_axis_tvalid === 1'b1 && bus.m_axis_tready === 1'b1 && irst === 1'b0) begin
      exp_t e;
      fire_cyc.push_back(cyc);
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL beat_unexpected: got data=%h tid=%0d, expected no beat",
                 bus.m_axis_tdata, bus.m_axis_tid);
      end else begin
        e = exp_q.pop_front();
        if ({bus.m_axis_tdata, bus.m_axis_tid} !== e) begin
          fails++;
          $display("FAIL beat_order: got data=%h tid=%0d, expected data=%h tid=%0d",
                   bus.m_axis_tdata, bus.m_axis_tid, e.data, e.tid);
        end
      end
    end
    if (!$isunknown(ogrant) && ogrant !== prev_gnt && ogrant !== '0) grant_log.push_back(ogrant);
    prev_gnt = ogrant;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge iclk);
    #1;
  endtask

  task automatic push_src(input int p, input logic [7:0] d, input logic l);
    src_q[p].push_back(beat_t'{d, l});
  endtask

  task automatic push_exp(input logic [7:0] d, input logic [1:0] t);
    exp_q.push_back(exp_t'{d, t});
  endtask

  task automatic wait_drain(input string name, input bit check_src);
    int t;
    int pend;
    t = 0;
    forever begin
      pend = 0;
      if (check_src) for (int p = 0; p < N; p++) pend += src_q[p].size();
      if ((exp_q.size() == 0 && obusy === 1'b0 && pend == 0) || t >= 400) break;
      tick(1);
      t++;
    end
    tests++;
    if (t >= 400) begin
      fails++;
      $display("FAIL %s_drain: timeout with %0d beats outstanding, expected 0", name, exp_q.size());
    end
  endtask

  task automatic pulse_reset();
    irst = 1'b1;
    tick(1);
    irst = 1'b0;
  endtask

  task automatic test_reset();
    irst = 1'b1;
    tick(3);
    tests++;
    if (ogrant !== '0 || obusy !== 1'b0) begin
      fails++;
      $display("FAIL reset_grant: got ogrant=%b obusy=%b, expected 0000 0", ogrant, obusy);
    end
    tests++;
    if (bus.m_axis_tvalid !== 1'b0 || bus.m_axis_tdata !== 8'h00 || bus.m_axis_tid !== 2'd0) begin
      fails++;
      $display("FAIL reset_out: got v=%b d=%h id=%0d, expected 0 00 0",
               bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tid);
    end
    tests++;
    if (bus.s_axis_tready !== '0) begin
      fails++;
      $display("FAIL reset_ready: got %b, expected 0000", bus.s_axis_tready);
    end
    irst = 1'b0;
    tick(3);
    tests++;
    if (ogrant !== '0 || obusy !== 1'b0) begin
      fails++;
      $display("FAIL idle_quiet: got ogrant=%b obusy=%b, expected 0000 0", ogrant, obusy);
    end
  endtask

  task automatic test_two_ports();
    grant_log.delete();
    push_src(0, 8'h41, 1'b1);
    push_src(2, 8'h42, 1'b1);
    push_exp(8'h41, 2'd0);
    push_exp(8'h42, 2'd2);
    wait_drain("two_ports", 1'b1);
    tests++;
    if (grant_log.size() != 2 || grant_log[0] !== 4'b0001 || grant_log[1] !== 4'b0100) begin
      fails++;
      $display("FAIL two_ports_grant: got %0d grants first=%b, expected 0001 then 0100",
               grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : 4'b0);
    end
  endtask

  task automatic test_contiguous();
    int t;
    pulse_reset();
    grant_log.delete();
    push_src(1, 8'h10, 1'b0);
    push_src(1, 8'h11, 1'b0);
    push_src(1, 8'h12, 1'b1);
    push_src(3, 8'h30, 1'b1);
    push_exp(8'h10, 2'd1);
    push_exp(8'h11, 2'd1);
    push_exp(8'h12, 2'd1);
    push_exp(8'h30, 2'd3);
    push_exp(8'h20, 2'd0);
    t = 0;
    while (ogrant !== 4'b0010 && t < 50) begin tick(1); t++; end
    tests++;
    if (t >= 50) begin
      fails++;
      $display("FAIL contig_grant1: got ogrant=%b, expected 0010", ogrant);
    end
    // Port 0 joins late: it must lose to port 3 since the pointer moves to 2.
    push_src(0, 8'h20, 1'b1);
    wait_drain("contig", 1'b1);
    tests++;
    if (grant_log.size() != 3 || grant_log[1] !== 4'b1000 || grant_log[2] !== 4'b0001) begin
      fails++;
      $display("FAIL contig_order: got %0d grants second=%b, expected 0010,1000,0001",
               grant_log.size(), (grant_log.size() > 1) ? grant_log[1] : 4'b0);
    end
  endtask

  task automatic test_backpressure();
    int t;
    bus.m_axis_tready = 1'b0;
    push_src(2, 8'h55, 1'b0);
    push_src(2, 8'h56, 1'b1);
    push_exp(8'h55, 2'd2);
    push_exp(8'h56, 2'd2);
    t = 0;
    while (bus.m_axis_tvalid !== 1'b1 && t < 50) begin tick(1); t++; end
    for (int i = 0; i < 5; i++) begin
      tick(1);
      tests++;
      if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== 8'h55 || bus.m_axis_tid !== 2'd2) begin
        fails++;
        $display("FAIL stall_hold: got v=%b d=%h id=%0d, expected 1 55 2",
                 bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tid);
      end
      tests++;
      if (bus.s_axis_tready !== 4'b0000) begin
        fails++;
        $display("FAIL stall_ready: got %b, expected 0000", bus.s_axis_tready);
      end
    end
    bus.m_axis_tready = 1'b1;
    wait_drain("stall", 1'b1);
  endtask

  task automatic test_ena_drop();
    int t;
    grant_log.delete();
    push_src(1, 8'h21, 1'b0);
    push_src(1, 8'h22, 1'b1);
    push_exp(8'h21, 2'd1);
    push_exp(8'h22, 2'd1);
    t = 0;
    while (!(bus.m_axis_tvalid === 1'b1 && bus.m_axis_tid === 2'd1) && t < 50) begin tick(1); t++; end
    iport_ena[1] = 1'b0;
    wait_drain("ena_drop", 1'b1);
    push_src(1, 8'h23, 1'b1);
    push_src(0, 8'h24, 1'b1);
    push_exp(8'h24, 2'd0);
    wait_drain("ena_masked", 1'b0);
    tick(10);
    tests++;
    if (grant_log.size() != 2 || grant_log[1] !== 4'b0001 || ogrant !== 4'b0000) begin
      fails++;
      $display("FAIL ena_mask: got %0d grants now=%b, expected 2 grants (0010,0001) now 0000",
               grant_log.size(), ogrant);
    end
    src_q[1].delete();
    tick(2);
    iport_ena = '1;
  endtask

  task automatic test_reset_mid();
    int t;
    bus.m_axis_tready = 1'b0;
    push_src(3, 8'h70, 1'b0);
    push_src(3, 8'h71, 1'b1);
    t = 0;
    while (bus.m_axis_tvalid !== 1'b1 && t < 50) begin tick(1); t++; end
    tick(1);
    irst = 1'b1;
    for (int p = 0; p < N; p++) src_q[p].delete();
    tick(1);
    tests++;
    if (bus.m_axis_tvalid !== 1'b0 || bus.m_axis_tdata !== 8'h00 || bus.m_axis_tid !== 2'd0) begin
      fails++;
      $display("FAIL midrst_out: got v=%b d=%h id=%0d, expected 0 00 0",
               bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tid);
    end
    tests++;
    if (ogrant !== '0 || obusy !== 1'b0 || bus.s_axis_tready !== '0) begin
      fails++;
      $display("FAIL midrst_ctl: got ogrant=%b obusy=%b ready=%b, expected 0000 0 0000",
               ogrant, obusy, bus.s_axis_tready);
    end
    irst = 1'b0;
    bus.m_axis_tready = 1'b1;
    grant_log.delete();
    push_src(3, 8'h72, 1'b1);
    push_src(0, 8'h03, 1'b1);
    push_exp(8'h03, 2'd0);
    push_exp(8'h72, 2'd3);
    wait_drain("midrst", 1'b1);
    tests++;
    if (grant_log.size() == 0 || grant_log[0] !== 4'b0001) begin
      fails++;
      $display("FAIL midrst_first: got first grant=%b, expected 0001",
               (grant_log.size() > 0) ? grant_log[0] : 4'b0);
    end
  endtask

  task automatic test_back_to_back();
    fire_cyc.delete();
    push_src(2, 8'h61, 1'b1);
    push_src(2, 8'h62, 1'b1);
    push_exp(8'h61, 2'd2);
    push_exp(8'h62, 2'd2);
    wait_drain("b2b", 1'b1);
    tests++;
    if (fire_cyc.size() != 2 || fire_cyc[1] - fire_cyc[0] != 3) begin
      fails++;
      $display("FAIL b2b_gap: got %0d beats spacing=%0d, expected 2 beats spacing 3",
               fire_cyc.size(), (fire_cyc.size() == 2) ? fire_cyc[1] - fire_cyc[0] : -1);
    end
  endtask

  task automatic test_all_four();
    logic [N-1:0] want;
    pulse_reset();
    grant_log.delete();
    for (int p = 0; p < N; p++) begin
      push_src(p, 8'hA0 + 8'(p), 1'b1);
      push_src(p, 8'hB0 + 8'(p), 1'b1);
    end
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < N; p++) push_exp(((r == 0) ? 8'hA0 : 8'hB0) + 8'(p), 2'(p));
    wait_drain("all4", 1'b1);
    tests++;
    if (grant_log.size() != 8) begin
      fails++;
      $display("FAIL all4_count: got %0d grants, expected 8", grant_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        want = 4'b0001 << (i % N);
        tests++;
        if (grant_log[i] !== want) begin
          fails++;
          $display("FAIL all4_order: grant %0d got %b, expected %b", i, grant_log[i], want);
        end
      end
    end
  endtask

  initial begin
    iport_ena         = '1;
    bus.m_axis_tready = 1'b1;
    test_reset();
    test_two_ports();
    test_contiguous();
    test_backpressure();
    test_ena_drop();
    test_reset_mid();
    test_back_to_back();
    test_all_four();
    tick(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
